// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-port register file.
package regfile_pkg;
  localparam int DW_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF = $clog2(NREG_DEF);
  localparam int REG_ZERO = 0;
  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with issue-over-write priority and a running busy count.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREG = NREG_DEF,
  parameter int AW = $clog2(NREG),
  parameter int NW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [NREG-1:0]  busy,
  output logic [AW:0]      busy_cnt,
  output logic             all_idle
);
  logic [NREG-1:0] set, clr;
  logic [AW:0] inc, dec, cnt_nxt;
  always_comb begin
    set = '0;
    clr = '0;
    inc = '0;
    dec = '0;
    if (iss_en && iss_addr != AW'(REG_ZERO)) set[iss_addr] = 1'b1;
    for (int k = 0; k < NW; k++)
      if (wr_en[k] && wr_addr[k*AW +: AW] != AW'(REG_ZERO)) clr[wr_addr[k*AW +: AW]] = 1'b1;
    // Only real bit transitions move the count, so it tracks the popcount exactly.
    for (int i = 0; i < NREG; i++) begin
      inc = inc + (AW+1)'(set[i] & ~busy[i]);
      dec = dec + (AW+1)'(clr[i] & busy[i] & ~set[i]);
    end
    cnt_nxt = busy_cnt + inc - dec;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= '0;
      busy_cnt <= '0;
      all_idle <= 1'b1;
    end else begin
      busy <= (busy & ~clr) | set;
      busy_cnt <= cnt_nxt;
      all_idle <= cnt_nxt == '0;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read / NW-write register file with hardwired zero register and busy scoreboard.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp import regfile_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW = $clog2(NREG),
  parameter int NR = 2,
  parameter int NW = 1,
  parameter logic [DW-1:0] R1_INIT = DW'(32'd1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_busy,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic [AW:0]      busy_cnt,
  output logic             all_idle
);
  logic [DW-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0] ra;
  regfile_scoreboard #(.NREG(NREG), .AW(AW), .NW(NW)) u_sb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy(busy), .busy_cnt(busy_cnt), .all_idle(all_idle)
  );
  // Ascending port order lets the highest port win on address collisions.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= (i == 1) ? R1_INIT : '0;
    end else begin
      for (int k = 0; k < NW; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] != AW'(REG_ZERO))
          regs[wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
    end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra = '0;
    for (int j = 0; j < NR; j++) begin
      ra = rd_addr[j*AW +: AW];
      rd_data[j*DW +: DW] = regs[ra];
      rd_busy[j] = busy[ra];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NW; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == ra && ra != AW'(REG_ZERO)) begin
          rd_data[j*DW +: DW] = wr_data[k*DW +: DW];
          rd_busy[j] = busy[ra] && iss_en && iss_addr == ra;
        end
`endif
    end
  end
endmodule
